// File: rtl/clkctl_pkg.sv
// Shared types and widths for the step/run/halt clock-enable controller.
package clkctl_pkg;

   typedef enum logic [1:0] {
      STEP = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   localparam int CNT_W = 32;

endpackage

// File: rtl/step_clock_controller_key_debouncer.sv
// Pushbutton front end: 2-flop synchronizer, stable-count debouncer and a
// one-cycle step_pulse on each debounced press (1->0 of the active-low key).
module key_debouncer #(
   parameter int DB_CYCLES = 1000000
) (
   input  logic clk_50MHz,
   input  logic rst,
   input  logic key_n,
   output logic step_pulse
);

   localparam int               DB_W    = $clog2(DB_CYCLES + 1);
   localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DB_CYCLES - 1);

   logic            key_meta;
   logic            key_sync;
   logic [1:0]      flush;
   logic            armed;
   logic            key_db;
   logic [DB_W-1:0] db_cnt;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_50MHz or posedge rst) begin
      if (rst) begin
         key_meta <= 1'b1;
         key_sync <= 1'b1;
      end else begin
         key_meta <= key_n;
         key_sync <= key_meta;
      end
   end

   // A press only counts once the key has been seen released after reset,
   // so a key held through reset release never produces a step.
   always_ff @(posedge clk_50MHz or posedge rst) begin
      if (rst) begin
         flush <= 2'b00;
         armed <= 1'b0;
      end else begin
         flush <= {flush[0], 1'b1};
         armed <= armed | (flush[1] & key_sync);
      end
   end

   always_ff @(posedge clk_50MHz or posedge rst) begin
      if (rst) begin
         db_cnt     <= '0;
         key_db     <= 1'b1;
         step_pulse <= 1'b0;
      end else begin
         step_pulse <= 1'b0;
         if (key_sync == key_db) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_LAST) begin
            db_cnt     <= '0;
            key_db     <= key_sync;
            step_pulse <= armed & ~key_sync;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/step_clock_controller.sv
// Processor clock-enable controller with STEP / RUN / HALT modes.
// Define CYCLE_COUNT_EN to build the 32-bit cpu_en pulse counter.
module step_clock_controller
   import clkctl_pkg::*;
#(
   parameter int RUN_DIV   = 50000000,
   parameter int DB_CYCLES = 1000000
) (
   input  logic             clk_50MHz,
   input  logic             rst,
   input  logic             sw_run,
   input  logic             key_step_n,
   input  logic             halt_req,
   input  logic             clr_halt,
   output logic             cpu_en,
   output logic [1:0]       mode,
   output logic [CNT_W-1:0] cycle_count
);

   localparam int               DIV_W    = $clog2(RUN_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

   logic             sw_meta;
   logic             sw_sync;
   logic             step_pulse;
   state_t           state;
   state_t           state_next;
   logic [DIV_W-1:0] div;
   logic [DIV_W-1:0] div_next;
   logic             en_next;

   always_ff @(posedge clk_50MHz or posedge rst) begin
      if (rst) begin
         sw_meta <= 1'b0;
         sw_sync <= 1'b0;
      end else begin
         sw_meta <= sw_run;
         sw_sync <= sw_meta;
      end
   end

   key_debouncer #(
      .DB_CYCLES (DB_CYCLES)
   ) u_key_debouncer (
      .clk_50MHz  (clk_50MHz),
      .rst        (rst),
      .key_n      (key_step_n),
      .step_pulse (step_pulse)
   );

   always_ff @(posedge clk_50MHz or posedge rst) begin
      if (rst) begin
         state  <= STEP;
         div    <= '0;
         cpu_en <= 1'b0;
      end else begin
         state  <= state_next;
         div    <= div_next;
         cpu_en <= en_next;
      end
   end

   // halt_req outranks sw_run; in HALT only a lone clr_halt releases.
   always_comb begin
      // NOTE: assign a default first so no path leaves a combinational output unassigned (latch).
      state_next = state;
      case (state)
         STEP: begin
            if (halt_req)    state_next = HALT;
            else if (sw_sync) state_next = RUN;
         end
         RUN: begin
            if (halt_req)     state_next = HALT;
            else if (!sw_sync) state_next = STEP;
         end
         HALT: begin
            if (clr_halt && !halt_req) state_next = STEP;
         end
         default: state_next = STEP;
      endcase
   end

   // The divider only runs while staying in RUN, so it restarts at 0 on every
   // entry and a pulse due on a leaving cycle is dropped.
   always_comb begin
      en_next  = 1'b0;
      div_next = '0;
      case (state)
         STEP: en_next = step_pulse & ~halt_req;
         RUN: begin
            if (state_next == RUN) begin
               if (div == DIV_LAST) begin
                  en_next = 1'b1;
               end else begin
                  div_next = div + 1'b1;
               end
            end
         end
         default: en_next = 1'b0;
      endcase
   end

   assign mode = state;

`ifdef CYCLE_COUNT_EN
   logic [CNT_W-1:0] count_q;

   always_ff @(posedge clk_50MHz or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_q + CNT_W'(cpu_en);
      end
   end

   assign cycle_count = count_q;
`else
   assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_step_clock_controller.sv
// Self-checking bench for step_clock_controller (RUN_DIV=4, DB_CYCLES=8),
// compared every cycle against a rule-level reference model.
module tb_step_clock_controller;

   localparam int RD = 4;
   localparam int DB = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        sw_run;
   logic        key_n;
   logic        halt_req;
   logic        clr_halt;
   logic        cpu_en;
   logic [1:0]  mode;
   logic [31:0] cycle_count;

   int total = 0;
   int bad   = 0;

   step_clock_controller #(
      .RUN_DIV   (RD),
      .DB_CYCLES (DB)
   ) dut (
      .clk_50MHz   (clk),
      .rst         (rst),
      .sw_run      (sw_run),
      .key_step_n  (key_n),
      .halt_req    (halt_req),
      .clr_halt    (clr_halt),
      .cpu_en      (cpu_en),
      .mode        (mode),
      .cycle_count (cycle_count)
   );

   always #5 clk = ~clk;

   // Reference model: inputs are seen two edges late; the debounced key flips
   // when the last DB seen samples all hold the new value; RUN pulses every
   // RD-th edge spent in RUN after entry.
   int          m_edge;
   bit          raw_q[$];
   bit          sw_q[$];
   bit          syn_q[$];
   bit          m_armed;
   bit          m_db;
   bit          m_sp;
   int          m_mode;
   int          m_age;
   bit          m_en;
   logic [31:0] m_cnt;
   bit          t_ks, t_ss, t_en, t_same;
   int          t_nm, t_j;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_edge = 0; raw_q.delete(); sw_q.delete(); syn_q.delete();
         m_armed = 0; m_db = 1; m_sp = 0; m_mode = 0; m_age = 0; m_en = 0; m_cnt = 0;
      end else begin
         t_ks = (m_edge < 2) ? 1'b1 : raw_q[m_edge-2];
         t_ss = (m_edge < 2) ? 1'b0 : sw_q[m_edge-2];
         raw_q.push_back(key_n);
         sw_q.push_back(sw_run);
         t_nm = m_mode;
         case (m_mode)
            0: if (halt_req) t_nm = 2; else if (t_ss) t_nm = 1;
            1: if (halt_req) t_nm = 2; else if (!t_ss) t_nm = 0;
            default: if (clr_halt && !halt_req) t_nm = 0;
         endcase
         t_j  = m_age + 1;
         t_en = 0;
         if (m_mode == 0 && m_sp && !halt_req) t_en = 1;
         if (m_mode == 1 && t_nm == 1 && (t_j % RD) == 0) t_en = 1;
         m_age  = (m_mode == 1 && t_nm == 1) ? t_j : 0;
         m_cnt  = m_cnt + 32'(m_en);
         m_en   = t_en;
         m_mode = t_nm;
         syn_q.push_back(t_ks);
         m_sp = 0;
         if (syn_q.size() >= DB) begin
            t_same = 1;
            for (int i = syn_q.size() - DB; i < syn_q.size(); i++)
               if (syn_q[i] != t_ks) t_same = 0;
            if (t_same && t_ks != m_db) begin
               m_sp = m_armed && !t_ks;
               m_db = t_ks;
            end
         end
         if (m_edge >= 2 && t_ks) m_armed = 1;
         m_edge++;
      end
   end

   function automatic logic [31:0] exp_count();
`ifdef CYCLE_COUNT_EN
      return m_cnt;
`else
      return 32'd0;
`endif
   endfunction

   task automatic test_reset();
      rst = 1; key_n = 1; sw_run = 0; halt_req = 0; clr_halt = 0;
      repeat (3) @(negedge clk);
      total++; if (cpu_en !== 1'b0) begin bad++; $display("FAIL reset_en got=%0b want=0", cpu_en); end
      total++; if (mode !== 2'd0) begin bad++; $display("FAIL reset_mode got=%0d want=0", mode); end
      total++; if (cycle_count !== 32'd0) begin bad++; $display("FAIL reset_count got=%0h want=0", cycle_count); end
      rst = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         total++;
         if (cpu_en !== 1'b0 || mode !== 2'd0 || cycle_count !== 32'd0) begin
            bad++; $display("FAIL idle cyc=%0d got en=%0b mode=%0d cnt=%0h want 0 0 0", i, cpu_en, mode, cycle_count);
         end
      end
   endtask

   task automatic test_step_press();
      bit pat[$];
      int pulses;
      logic [31:0] want;
      for (int n = 0; n < 3; n++) begin
         pat.delete();
         for (int i = 0; i < 5; i++) pat.push_back(1'($urandom_range(0, 1)));
         for (int i = 0; i < 12; i++) pat.push_back(1'b0);
         for (int i = 0; i < 14; i++) pat.push_back(1'b1);
         pulses = 0;
         foreach (pat[i]) begin
            key_n = pat[i];
            @(negedge clk);
            total++;
            if (cpu_en !== m_en || mode !== 2'(m_mode) || cycle_count !== exp_count()) begin
               bad++; $display("FAIL step cyc=%0d got en=%0b mode=%0d cnt=%0h want %0b %0d %0h", i, cpu_en, mode, cycle_count, m_en, m_mode, exp_count());
            end
            if (cpu_en === 1'b1) pulses++;
         end
`ifdef CYCLE_COUNT_EN
         want = 32'(n + 1);
`else
         want = 32'd0;
`endif
         total++; if (pulses !== 1) begin bad++; $display("FAIL step_pulses got=%0d want=1", pulses); end
         total++; if (cycle_count !== want) begin bad++; $display("FAIL step_count got=%0h want=%0h", cycle_count, want); end
      end
   endtask

   task automatic test_run();
      int t_entry = 0, t_first = 0, last = 0, len;
      len = 20 + $urandom_range(0, 7);
      sw_run = 1;
      for (int i = 1; i <= len; i++) begin
         @(negedge clk);
         total++;
         if (cpu_en !== m_en || mode !== 2'(m_mode) || cycle_count !== exp_count()) begin
            bad++; $display("FAIL run cyc=%0d got en=%0b mode=%0d cnt=%0h want %0b %0d %0h", i, cpu_en, mode, cycle_count, m_en, m_mode, exp_count());
         end
         if (mode === 2'd1 && t_entry == 0) t_entry = i;
         if (cpu_en === 1'b1) begin
            if (t_first == 0) t_first = i;
            else begin
               total++; if (i - last != RD) begin bad++; $display("FAIL run_spacing got=%0d want=%0d", i - last, RD); end
            end
            last = i;
         end
      end
      total++; if (t_entry != 3) begin bad++; $display("FAIL run_entry got=%0d want=3", t_entry); end
      total++; if (t_first - t_entry != RD) begin bad++; $display("FAIL run_first got=%0d want=%0d", t_first - t_entry, RD); end
   endtask

   task automatic test_halt();
      bit found = 0;
      bit pat[$];
      for (int i = 0; i < 2 * RD && !found; i++) begin
         @(negedge clk);
         if (m_mode == 1 && ((m_age + 1) % RD) == 0) found = 1;
      end
      total++; if (!found) begin bad++; $display("FAIL halt_wait got=timeout want=divider_at_last"); end
      halt_req = 1;
      @(negedge clk);
      halt_req = 0;
      total++; if (cpu_en !== 1'b0) begin bad++; $display("FAIL halt_suppress got=%0b want=0", cpu_en); end
      total++; if (mode !== 2'd2) begin bad++; $display("FAIL halt_mode got=%0d want=2", mode); end
      for (int i = 0; i < 12; i++) pat.push_back(1'b0);
      for (int i = 0; i < 14; i++) pat.push_back(1'b1);
      foreach (pat[i]) begin
         key_n  = pat[i];
         sw_run = 1'($urandom_range(0, 1));
         @(negedge clk);
         total++;
         if (cpu_en !== 1'b0 || mode !== 2'd2 || cpu_en !== m_en || mode !== 2'(m_mode)) begin
            bad++; $display("FAIL halt_hold cyc=%0d got en=%0b mode=%0d want 0 2", i, cpu_en, mode);
         end
      end
      sw_run = 1; halt_req = 1; clr_halt = 1;
      @(negedge clk);
      halt_req = 0; clr_halt = 0;
      total++; if (mode !== 2'd2) begin bad++; $display("FAIL halt_both got=%0d want=2", mode); end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_clr_halt();
      int pulses = 0;
      clr_halt = 1;
      @(negedge clk);
      clr_halt = 0;
      total++; if (mode !== 2'd0) begin bad++; $display("FAIL clr_step got=%0d want=0", mode); end
      @(negedge clk);
      total++; if (mode !== 2'd1) begin bad++; $display("FAIL clr_run got=%0d want=1", mode); end
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         total++;
         if (cpu_en !== m_en || mode !== 2'(m_mode) || cycle_count !== exp_count()) begin
            bad++; $display("FAIL clr cyc=%0d got en=%0b mode=%0d cnt=%0h want %0b %0d %0h", i, cpu_en, mode, cycle_count, m_en, m_mode, exp_count());
         end
         if (cpu_en === 1'b1) pulses++;
      end
      total++; if (pulses != 3) begin bad++; $display("FAIL clr_pulses got=%0d want=3", pulses); end
   endtask

   task automatic test_reset_mid_run();
      int pulses = 0;
      repeat ($urandom_range(1, 6)) @(negedge clk);
      #2 rst = 1; key_n = 0;
      #1;
      total++; if (cpu_en !== 1'b0) begin bad++; $display("FAIL abort_en got=%0b want=0", cpu_en); end
      total++; if (mode !== 2'd0) begin bad++; $display("FAIL abort_mode got=%0d want=0", mode); end
      total++; if (cycle_count !== 32'd0) begin bad++; $display("FAIL abort_count got=%0h want=0", cycle_count); end
      @(negedge clk);
      rst = 0; sw_run = 0;
      for (int i = 0; i < 34; i++) begin
         key_n = (i < 20) ? 1'b0 : 1'b1;
         @(negedge clk);
         total++;
         if (cpu_en !== m_en || mode !== 2'(m_mode) || cycle_count !== exp_count()) begin
            bad++; $display("FAIL held cyc=%0d got en=%0b mode=%0d cnt=%0h want %0b %0d %0h", i, cpu_en, mode, cycle_count, m_en, m_mode, exp_count());
         end
         if (cpu_en === 1'b1) pulses++;
      end
      total++; if (pulses != 0) begin bad++; $display("FAIL held_pulses got=%0d want=0", pulses); end
   endtask

`ifdef CYCLE_COUNT_EN
   task automatic test_wrap();
      force dut.count_q = 32'hFFFF_FFFF;
      m_cnt = 32'hFFFF_FFFF;
      @(negedge clk);
      release dut.count_q;
      total++; if (cycle_count !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap_preset got=%0h want=ffffffff", cycle_count); end
      for (int i = 0; i < 26; i++) begin
         key_n = (i < 12) ? 1'b0 : 1'b1;
         @(negedge clk);
         total++;
         if (cpu_en !== m_en || mode !== 2'(m_mode) || cycle_count !== exp_count()) begin
            bad++; $display("FAIL wrap cyc=%0d got en=%0b mode=%0d cnt=%0h want %0b %0d %0h", i, cpu_en, mode, cycle_count, m_en, m_mode, exp_count());
         end
      end
      total++; if (cycle_count !== 32'd0) begin bad++; $display("FAIL wrap_zero got=%0h want=0", cycle_count); end
   endtask
`endif

   task automatic test_random();
      int hold = 0;
      for (int i = 0; i < 400; i++) begin
         if (hold == 0) begin
            if ($urandom_range(0, 1) == 1) key_n = ~key_n;
            hold = $urandom_range(1, 14);
         end
         hold--;
         if ($urandom_range(0, 29) == 0) sw_run = ~sw_run;
         halt_req = ($urandom_range(0, 39) == 0);
         clr_halt = ($urandom_range(0, 14) == 0);
         @(negedge clk);
         total++;
         if (cpu_en !== m_en || mode !== 2'(m_mode) || cycle_count !== exp_count()) begin
            bad++; $display("FAIL rand cyc=%0d got en=%0b mode=%0d cnt=%0h want %0b %0d %0h", i, cpu_en, mode, cycle_count, m_en, m_mode, exp_count());
         end
      end
      halt_req = 0; clr_halt = 0;
   endtask

   initial begin
      test_reset();
      test_step_press();
      test_run();
      test_halt();
      test_clr_halt();
      test_reset_mid_run();
`ifdef CYCLE_COUNT_EN
      test_wrap();
`endif
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
